sync_down_counter: RTL and testbench
====================================

# sync_down_counter

Synchronous, loadable down counter built from JK flip-flop cells that share one clock, with no rippled clocks. It counts in the opposite direction to the team's ripple up counter. It provides parallel load, optional auto-reload and a one-cycle terminal-count pulse. It serves as the countdown and timeout element alongside the up counters in the counter library.

## Interface
Parameters:
- WIDTH, default 4: counter width in bits; legal range 2–16.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; one decrement per cycle while high.
- load  in  1  parallel load strobe.
- din  in  WIDTH  load value.
- auto_reload  in  1  at zero with en, reload from last loaded value instead of wrapping.
- q  out  WIDTH  count value, registered.
- qb  out  WIDTH  bitwise complement of q, registered.
- tc  out  1  terminal-count pulse, registered.

Reset behaviour is fixed: one clock, synchronous active-high reset.

## Operation
- Priority per rising edge is reset > load > en > hold.
- **reset:** q=0, qb=all ones, tc=0, internal reload register rl=0.
- **load:**
  - q<=din and rl<=din.
  - tc<=0.
  - en is ignored that cycle.
- **en with q!=0:** q<=q-1.
- **en with q==0:**
  - auto_reload=1: q<=rl.
  - auto_reload=0: q<=all ones (modulo 2^WIDTH wrap).
- **Idle (en=0, load=0):** q holds.
- **tc:**
  - Set to 1 only on an edge where a decrement takes q from 1 to 0. Otherwise tc<=0.
  - tc is therefore high for exactly the first cycle q shows 0 after counting down.
  - Loading 0 never raises tc.
  - Holding at 0 keeps tc high for one cycle only.
- **Auto-reload with rl=0:** q stays 0 and tc stays 0; a zero-length period produces no pulse.
- **auto_reload changes:** sampled only at the wrap edge; it may change at any time.
- **qb:** always ~q in the same cycle; never stale.

## Timing
- All outputs are registered; latency from any input to q/qb/tc is 1 clock.
- No combinational input-to-output path.
- With continuous en, period from load of N (N>0) to tc:
  - N cycles after the load edge.
  - Next tc: N+1 cycles later with auto_reload; 2^WIDTH cycles later without it.
- **Reset mid-count:** the next edge forces the reset values. No pending tc survives reset.
- **load and en asserted together:** load wins; the decrement starts on the following enabled cycle.
- **load asserted on the edge where q would go 1->0:** load wins and tc stays 0.

## Structure
- Sub-module jkff_sync: one-bit JK flip-flop on the rising edge of clock.
  - Synchronous active-high reset to q=0, qb=1.
  - JK=00 hold, 01 clear, 10 set, 11 toggle.
  - The counter instantiates WIDTH of them.
- Per-bit JK drive computed combinationally in sync_down_counter:
  - Counting: J=K=en & (all lower bits of q are 0). This is the down-count toggle condition; bit 0 toggles whenever en.
  - Load, reload and wrap: J=v[i], K=~v[i], where v is din, rl or all ones.
- rl is a plain WIDTH-bit register. tc is a one-bit register fed by en & ~load & (q==1).
- Shared package counter_pkg holds:
  - JK code constants (JK_HOLD, JK_CLR, JK_SET, JK_TGL).
  - Width limits (CNT_WIDTH_MIN=2, CNT_WIDTH_MAX=16).
- The ripple up counter's JK cell may migrate to these constants later.

## Test plan
- **Reset:** WIDTH=4, run counting, assert reset one cycle -> next edge q=0, qb=4'hF, tc=0. Then en=1, auto_reload=0 -> q=F,E,D,…
- **Load and count:** load din=5, then en=1 continuously -> q=5,4,3,2,1,0. tc=1 only in the cycle q=0. Next q=F with tc=0.
- **Auto-reload:** load 3, auto_reload=1, en=1 -> q=3,2,1,0,3,2,1,0. tc high exactly at each q=0, i.e. every 4 cycles.
- **Priority:**
  - load=1 and en=1 together with din=9 -> q=9, no decrement.
  - load din=7 on the edge where q=1 would go to 0 -> q=7, tc=0.
- **Hold at zero:** count to 0 then en=0 for 5 cycles -> q stays 0, tc high for one cycle only. Separately, load 0 with auto_reload=1, en=1 -> q stays 0, tc never asserts.
- **Width sweep:** WIDTH=2 and WIDTH=16 -> load 1 and en give tc after 1 cycle. Wrap yields all ones. qb==~q checked every cycle.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counter library: JK cell drive codes and width limits.
package counter_pkg;

    localparam int CNT_WIDTH_MIN = 2;
    localparam int CNT_WIDTH_MAX = 16;

    // {J,K} drive codes for the JK flip-flop cells
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_code_e;

endpackage

// File: rtl/jkff_sync.sv
// One-bit JK flip-flop on the rising clock edge, synchronous active-high reset.
// q and qb are kept as separate registers so qb is never a derived wire.
module jkff_sync
    import counter_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    logic     r_q;
    logic     r_qb;
    jk_code_e w_code;

    assign w_code = jk_code_e'({j, k});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q  <= 1'b0;
            r_qb <= 1'b1;
        end else begin
            case (w_code)
                JK_CLR: begin
                    r_q  <= 1'b0;
                    r_qb <= 1'b1;
                end
                JK_SET: begin
                    r_q  <= 1'b1;
                    r_qb <= 1'b0;
                end
                JK_TGL: begin
                    r_q  <= ~r_q;
                    r_qb <= ~r_qb;
                end
                default: begin
                    r_q  <= r_q;
                    r_qb <= r_qb;
                end
            endcase
        end
    end

    assign q  = r_q;
    assign qb = r_qb;

endmodule

// File: rtl/sync_down_counter.sv
// Synchronous loadable down counter built from shared-clock JK cells, with
// optional auto-reload from the last loaded value and a one-cycle terminal-count pulse.
module sync_down_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc
);

    generate
        if (WIDTH < CNT_WIDTH_MIN || WIDTH > CNT_WIDTH_MAX) begin : g_width_check
            $error("sync_down_counter: WIDTH out of supported range");
        end
    endgenerate

    logic [WIDTH-1:0] r_rl;
    logic             r_tc;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qb;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_low_zero;
    logic [WIDTH-1:0] w_wrap_val;
    logic             w_q_zero;
    logic             w_q_one;

    // A bit toggles on a down count when every bit below it is 0 (borrow chain).
    assign w_low_zero[0] = 1'b1;
    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_borrow
            assign w_low_zero[gi] = w_low_zero[gi-1] & ~w_q[gi-1];
        end
    endgenerate

    assign w_q_zero   = (w_q == '0);
    assign w_q_one    = (w_q == WIDTH'(1));
    assign w_wrap_val = auto_reload ? r_rl : '1;

    always_comb begin
        w_j = '0;
        w_k = '0;
        if (load) begin
            w_j = din;
            w_k = ~din;
        end else if (en) begin
            if (w_q_zero) begin
                w_j = w_wrap_val;
                w_k = ~w_wrap_val;
            end else begin
                w_j = w_low_zero;
                w_k = w_low_zero;
            end
        end
    end

    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            jkff_sync u_jkff (
                .clock (clock),
                .reset (reset),
                .j     (w_j[gi]),
                .k     (w_k[gi]),
                .q     (w_q[gi]),
                .qb    (w_qb[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rl <= '0;
            r_tc <= 1'b0;
        end else begin
            if (load) begin
                r_rl <= din;
            end
            // tc only marks the 1 -> 0 decrement; loads and wraps never raise it
            r_tc <= en & ~load & w_q_one;
        end
    end

    assign q  = w_q;
    assign qb = w_qb;
    assign tc = r_tc;

endmodule

// File: tb/tb_sync_down_counter.sv
// Bench for sync_down_counter: WIDTH 4, 2 and 16 instances driven in parallel,
// checked every cycle against an arithmetic model plus hand-computed points.
module tb_sync_down_counter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic        auto_reload = 1'b0;
    logic [15:0] din = '0;

    logic [3:0]  q4, qb4;
    logic [1:0]  q2, qb2;
    logic [15:0] q16, qb16;
    logic        tc4, tc2, tc16;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    int unsigned mq [3];
    int unsigned mrl [3];
    bit          mtc [3];
    int          widths [3] = '{4, 2, 16};

    always #5 clock = ~clock;

    sync_down_counter #(.WIDTH(4)) u_dut4 (
        .clock(clock), .reset(reset), .en(en), .load(load), .din(din[3:0]),
        .auto_reload(auto_reload), .q(q4), .qb(qb4), .tc(tc4));

    sync_down_counter #(.WIDTH(2)) u_dut2 (
        .clock(clock), .reset(reset), .en(en), .load(load), .din(din[1:0]),
        .auto_reload(auto_reload), .q(q2), .qb(qb2), .tc(tc2));

    sync_down_counter #(.WIDTH(16)) u_dut16 (
        .clock(clock), .reset(reset), .en(en), .load(load), .din(din),
        .auto_reload(auto_reload), .q(q16), .qb(qb16), .tc(tc16));

    // Behavioural model: plain arithmetic on the documented rules
    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            int unsigned mask;
            mask = (32'd1 << widths[i]) - 1;
            if (reset) begin
                mq[i] = 0; mrl[i] = 0; mtc[i] = 1'b0;
            end else if (load) begin
                mq[i] = din & mask; mrl[i] = din & mask; mtc[i] = 1'b0;
            end else if (en) begin
                mtc[i] = (mq[i] == 1);
                if (mq[i] == 0) mq[i] = auto_reload ? mrl[i] : mask;
                else            mq[i] = mq[i] - 1;
            end else begin
                mtc[i] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            int unsigned dq [3];
            int unsigned dqb [3];
            bit          dtc [3];
            dq  = '{{28'd0, q4}, {30'd0, q2}, {16'd0, q16}};
            dqb = '{{28'd0, qb4}, {30'd0, qb2}, {16'd0, qb16}};
            dtc = '{tc4, tc2, tc16};
            for (int i = 0; i < 3; i++) begin
                int unsigned mask;
                mask = (32'd1 << widths[i]) - 1;
                check($sformatf("model_q_w%0d", widths[i]), dq[i], mq[i]);
                check($sformatf("model_qb_w%0d", widths[i]), dqb[i], ~mq[i] & mask);
                check($sformatf("model_tc_w%0d", widths[i]), dtc[i], mtc[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic lit4(input string name, input int unsigned exp_q, input bit exp_tc);
        check({name, "_q"}, q4, exp_q);
        check({name, "_tc"}, tc4, exp_tc);
    endtask

    initial begin
        int unsigned seq_q [8];
        bit          seq_tc [8];

        reset = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        lit4("reset", 0, 0);
        check("reset_qb", qb4, 4'hF);

        reset = 1'b0; en = 1'b1; auto_reload = 1'b0;
        tick(); lit4("wrap_from_reset", 4'hF, 0);
        tick(); lit4("count_e", 4'hE, 0);
        tick(); lit4("count_d", 4'hD, 0);

        reset = 1'b1;
        tick(); lit4("reset_mid", 0, 0);
        check("reset_mid_qb", qb4, 4'hF);
        reset = 1'b0;

        load = 1'b1; din = 16'd5;
        tick(); lit4("load5", 5, 0);
        load = 1'b0;
        for (int n = 4; n >= 0; n--) begin
            tick(); lit4($sformatf("down_%0d", n), n, n == 0);
        end
        tick(); lit4("wrap_after_tc", 4'hF, 0);

        load = 1'b1; din = 16'd3; auto_reload = 1'b1;
        tick(); lit4("load3_ar", 3, 0);
        load = 1'b0;
        seq_q  = '{2, 1, 0, 3, 2, 1, 0, 3};
        seq_tc = '{0, 0, 1, 0, 0, 0, 1, 0};
        for (int n = 0; n < 8; n++) begin
            tick(); lit4($sformatf("ar_step%0d", n), seq_q[n], seq_tc[n]);
        end
        auto_reload = 1'b0;

        load = 1'b1; din = 16'd9;
        tick(); lit4("load_beats_en", 9, 0);
        din = 16'd2;
        tick(); lit4("load2", 2, 0);
        load = 1'b0;
        tick(); lit4("at_one", 1, 0);
        load = 1'b1; din = 16'd7;
        tick(); lit4("load_at_one", 7, 0);
        load = 1'b0;

        load = 1'b1; din = 16'd2;
        tick();
        load = 1'b0;
        tick(); tick(); lit4("hold_reach0", 0, 1);
        en = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick(); lit4($sformatf("hold0_%0d", n), 0, 0);
        end

        load = 1'b1; din = 16'd0; auto_reload = 1'b1; en = 1'b1;
        tick(); lit4("load0", 0, 0);
        load = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick(); lit4($sformatf("rl0_%0d", n), 0, 0);
        end

        auto_reload = 1'b0; load = 1'b1; din = 16'd1;
        tick();
        check("w2_load1", q2, 1);
        check("w16_load1", q16, 1);
        load = 1'b0;
        tick();
        check("w2_tc", tc2, 1);
        check("w16_tc", tc16, 1);
        check("w2_q0", q2, 0);
        tick();
        check("w2_wrap", q2, 2'b11);
        check("w16_wrap", q16, 16'hFFFF);
        check("w16_wrap_qb", qb16, 16'h0000);
        check("w16_wrap_tc", tc16, 0);

        en = 1'b0;
        tick();
        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
